// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for bit-serial adder sequencers: state encoding and sizing helpers.
package serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bit counter width; never below one bit so a 2-bit adder still has a counter.
    function automatic int cnt_bits(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// Single-bit full adder cell used as the only arithmetic element of the serial adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic half_sum;

    assign half_sum = a ^ b;
    assign s        = half_sum ^ ci;
    assign co       = (a & b) | (ci & half_sum);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add sequencer: loads two operands and a carry-in, adds them LSB-first
// through one full adder (one bit per clock), then presents sum/carry-out until taken.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | waiting for operands, in_ready high
// ST_RUN  | one bit added per cycle, counter tracks the bit position
// ST_DONE | result registered, out_valid high until out_ready
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int               CNT_W    = cnt_bits(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             c_reg;
    logic [CNT_W-1:0] cnt;
    logic             fa_sum;
    logic             fa_carry;

    // Acceptance is tied directly to the state register so it drops the cycle after accept.
    assign in_ready = (state == ST_IDLE);

    full_adder u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (c_reg),
        .s  (fa_sum),
        .co (fa_carry)
    );

    // Sequencer: operand capture, per-bit shift/add, result hold and output handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
            c_reg     <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sh  <= op_a;
                        b_sh  <= op_b;
                        c_reg <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= {fa_sum, sum_sh[WIDTH-1:1]};
                    c_reg  <= fa_carry;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        sum       <= {fa_sum, sum_sh[WIDTH-1:1]};
                        cout      <= fa_carry;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random checks of the bit-serial add sequencer at WIDTH=8.
module tb_serial_adder_ctrl;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       cin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       cout;
    logic       busy;

    int passed = 0;
    int total  = 0;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one operand set at a negedge, then waits for out_valid.
    // lat counts negedges from the presenting cycle (cycle 0); ok=0 on timeout.
    task automatic run_add(input logic [7:0] a, input logic [7:0] b, input logic c,
                           output logic [7:0] s, output logic co, output int lat,
                           output bit ok);
        ok  = 1'b0;
        lat = 0;
        s   = '0;
        co  = 1'b0;
        for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
        if (!in_ready) return;
        op_a = a; op_b = b; cin = c; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        for (int i = 0; i < 40 && !out_valid; i++) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) return;
        s  = sum;
        co = cout;
        ok = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op_a = '0; op_b = '0; cin = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({in_ready, out_valid, busy, cout, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00})
            $display("FAIL reset_outputs: got rdy=%b vld=%b busy=%b cout=%b sum=%h, want 1 0 0 0 00",
                     in_ready, out_valid, busy, cout, sum);
        else passed++;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({in_ready, out_valid, busy} !== 3'b100)
            $display("FAIL post_reset_idle: got rdy=%b vld=%b busy=%b, want 1 0 0", in_ready, out_valid, busy);
        else passed++;
    endtask

    task automatic test_basic();
        logic [7:0] s; logic co; int lat; bit ok;
        out_ready = 1'b1;
        run_add(8'h5A, 8'h3C, 1'b0, s, co, lat, ok);
        total++;
        if (!ok || {co, s} !== 9'h096)
            $display("FAIL basic_5a_3c: got ok=%0d cout=%b sum=%h, want cout=0 sum=96", ok, co, s);
        else passed++;
        total++;
        if (lat !== 9)
            $display("FAIL basic_latency: got %0d cycles, want 9", lat);
        else passed++;
        total++;
        if (busy !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL basic_done_flags: got busy=%b rdy=%b, want 1 0", busy, in_ready);
        else passed++;
        @(negedge clk);
        total++;
        if ({out_valid, in_ready, busy} !== 3'b010)
            $display("FAIL basic_pulse_end: got vld=%b rdy=%b busy=%b, want 0 1 0", out_valid, in_ready, busy);
        else passed++;
    endtask

    task automatic test_carry();
        logic [7:0] s; logic co; int lat; bit ok;
        out_ready = 1'b1;
        run_add(8'hFF, 8'h01, 1'b0, s, co, lat, ok);
        total++;
        if (!ok || {co, s} !== 9'h100)
            $display("FAIL carry_ff_01: got ok=%0d cout=%b sum=%h, want cout=1 sum=00", ok, co, s);
        else passed++;
        @(negedge clk);
        run_add(8'hFF, 8'hFF, 1'b1, s, co, lat, ok);
        total++;
        if (!ok || {co, s} !== 9'h1FF)
            $display("FAIL carry_ff_ff_1: got ok=%0d cout=%b sum=%h, want cout=1 sum=ff", ok, co, s);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [7:0] s; logic co; int lat; bit ok; int bad;
        out_ready = 1'b0;
        run_add(8'h21, 8'h43, 1'b1, s, co, lat, ok);
        total++;
        if (!ok || {co, s} !== 9'h065)
            $display("FAIL bp_result: got ok=%0d cout=%b sum=%h, want cout=0 sum=65", ok, co, s);
        else passed++;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if ({out_valid, in_ready, busy, cout, sum} !== {3'b101, 1'b0, 8'h65}) bad++;
        end
        total++;
        if (bad != 0)
            $display("FAIL bp_hold: %0d of 5 cycles changed, last vld=%b rdy=%b sum=%h, want vld=1 rdy=0 sum=65",
                     bad, out_valid, in_ready, sum);
        else passed++;
        out_ready = 1'b1;
        @(negedge clk);
        total++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL bp_release: got vld=%b rdy=%b, want 0 1", out_valid, in_ready);
        else passed++;
        total++;
        if ({cout, sum} !== 9'h065)
            $display("FAIL bp_sum_retained: got cout=%b sum=%h, want cout=0 sum=65", cout, sum);
        else passed++;
    endtask

    task automatic test_ignore_busy();
        int n;
        out_ready = 1'b1;
        op_a = 8'h12; op_b = 8'h34; cin = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        op_a = 8'hC8; op_b = 8'h64; cin = 1'b0;
        total++;
        if (in_ready !== 1'b0 || busy !== 1'b1)
            $display("FAIL busy_in_ready: got rdy=%b busy=%b, want 0 1", in_ready, busy);
        else passed++;
        n = 0;
        while (!out_valid && n < 40) begin @(negedge clk); n++; end
        total++;
        if (!out_valid || {cout, sum} !== 9'h047)
            $display("FAIL busy_first_result: got vld=%b cout=%b sum=%h, want 1 0 47", out_valid, cout, sum);
        else passed++;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1)
            $display("FAIL busy_back_idle: got rdy=%b, want 1", in_ready);
        else passed++;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin @(negedge clk); n++; end
        total++;
        if (!out_valid || {cout, sum} !== 9'h12C)
            $display("FAIL busy_second_result: got vld=%b cout=%b sum=%h, want 1 1 2c", out_valid, cout, sum);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [7:0] s; logic co; int lat; bit ok;
        out_ready = 1'b1;
        run_add(8'h0F, 8'hF0, 1'b0, s, co, lat, ok);
        total++;
        if (!ok || {co, s} !== 9'h0FF)
            $display("FAIL b2b_first: got ok=%0d cout=%b sum=%h, want cout=0 sum=ff", ok, co, s);
        else passed++;
        @(negedge clk);
        run_add(8'h7F, 8'h7F, 1'b1, s, co, lat, ok);
        total++;
        if (!ok || {co, s} !== 9'h0FF || lat !== 9)
            $display("FAIL b2b_second: got ok=%0d cout=%b sum=%h lat=%0d, want cout=0 sum=ff lat=9",
                     ok, co, s, lat);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] s; logic co; int lat; bit ok;
        out_ready = 1'b1;
        op_a = 8'hAA; op_b = 8'h55; cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({in_ready, out_valid, busy, cout, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00})
            $display("FAIL rst_mid_run: got rdy=%b vld=%b busy=%b cout=%b sum=%h, want 1 0 0 0 00",
                     in_ready, out_valid, busy, cout, sum);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_add(8'h81, 8'h80, 1'b1, s, co, lat, ok);
        total++;
        if (!ok || {co, s} !== 9'h102)
            $display("FAIL rst_fresh_add: got ok=%0d cout=%b sum=%h, want cout=1 sum=02", ok, co, s);
        else passed++;
        @(negedge clk);
        // reset while holding a result in DONE
        out_ready = 1'b0;
        run_add(8'h33, 8'h44, 1'b0, s, co, lat, ok);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({in_ready, out_valid, busy, cout, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00})
            $display("FAIL rst_in_done: got rdy=%b vld=%b busy=%b cout=%b sum=%h, want 1 0 0 0 00",
                     in_ready, out_valid, busy, cout, sum);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [7:0] a, b, s; logic c, co; int lat; bit ok; logic [8:0] exp;
        int errs;
        errs = 0;
        for (int t = 0; t < 1000; t++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            c = 1'($urandom_range(0, 1));
            exp = {1'b0, a} + {1'b0, b} + {8'h00, c};
            out_ready = 1'($urandom_range(0, 1));
            run_add(a, b, c, s, co, lat, ok);
            total++;
            if (!ok || {co, s} !== exp) begin
                if (errs < 10)
                    $display("FAIL rand_%0d: a=%h b=%h c=%b got ok=%0d {cout,sum}=%h, want %h",
                             t, a, b, c, ok, {co, s}, exp);
                errs++;
            end else passed++;
            for (int k = 0; k < 20 && out_valid; k++) begin
                out_ready = (k == 19) ? 1'b1 : 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            total++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                $display("FAIL rand_%0d_drain: got vld=%b rdy=%b, want 0 1", t, out_valid, in_ready);
            end else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_backpressure();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
